mul_issue: RTL and testbench

MUL_ISSUE -- requirements
Module: mul_issue

---
 rtl/mul_issue.sv | 127 ++++++++++++
 tb/tb_mul_issue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue.sv
// Issue/sequencing control between the EX stage and an external multi-cycle multiplier.
// Owns the architectural HI/LO registers and folds MADD/MSUB accumulation into the write-back.
module mul_issue (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic        flush_i,
    input  logic        mul_ready_i,
    input  logic [63:0] mul_result_i,
    output logic        mul_start_o,
    output logic        mul_annul_o,
    output logic        mul_signed_o,
    output logic [31:0] mul_opdata1_o,
    output logic [31:0] mul_opdata2_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN,
        ABORT
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_MADD  = 3'b011,
        OP_MADDU = 3'b100,
        OP_MSUB  = 3'b101,
        OP_MSUBU = 3'b110,
        OP_RSVD  = 3'b111
    } op_t;

    state_t      state;
    op_t         ex_op;
    op_t         op_q;
    logic        mul_op;
    logic        issue_signed;
    logic [63:0] wr_val;

    assign ex_op        = op_t'(ex_op_i);
    assign mul_op       = ex_valid_i && (ex_op != OP_NONE) && (ex_op != OP_RSVD);
    assign issue_signed = (ex_op == OP_MULT) || (ex_op == OP_MADD) || (ex_op == OP_MSUB);

    // Write-back value uses the op latched at issue, never the live EX op.
    always_comb begin
        wr_val = mul_result_i;
        case (op_q)
            OP_MADD, OP_MADDU: wr_val = {hi_o, lo_o} + mul_result_i;
            OP_MSUB, OP_MSUBU: wr_val = {hi_o, lo_o} - mul_result_i;
            default:           wr_val = mul_result_i;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        if (resetn) begin
            case (state)
                IDLE:         stall_o = mul_op && !flush_i;
                BUSY:         stall_o = !mul_ready_i;
                DRAIN, ABORT: stall_o = mul_op;
                default:      stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            op_q          <= OP_NONE;
            mul_start_o   <= 1'b0;
            mul_annul_o   <= 1'b0;
            mul_signed_o  <= 1'b0;
            mul_opdata1_o <= '0;
            mul_opdata2_o <= '0;
            hi_o          <= '0;
            lo_o          <= '0;
            done_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul_op && !flush_i) begin
                        op_q          <= ex_op;
                        mul_opdata1_o <= rs_i;
                        mul_opdata2_o <= rt_i;
                        mul_signed_o  <= issue_signed;
                        mul_start_o   <= 1'b1;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    // Flush beats a same-cycle ready: the result is discarded.
                    if (flush_i) begin
                        mul_start_o <= 1'b0;
                        mul_annul_o <= 1'b1;
                        state       <= ABORT;
                    end else if (mul_ready_i) begin
                        {hi_o, lo_o} <= wr_val;
                        done_o       <= 1'b1;
                        mul_start_o  <= 1'b0;
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                ABORT: begin
                    mul_annul_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// Directed self-checking bench for mul_issue; the bench plays the multiplier
// and supplies hand-computed products.
module tb_mul_issue;

    logic        clk;
    logic        resetn;
    logic        ex_valid_i;
    logic [2:0]  ex_op_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic        flush_i;
    logic        mul_ready_i;
    logic [63:0] mul_result_i;
    logic        mul_start_o;
    logic        mul_annul_o;
    logic        mul_signed_o;
    logic [31:0] mul_opdata1_o;
    logic [31:0] mul_opdata2_o;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        done_o;

    int unsigned n_checks;
    int unsigned n_fail;

    mul_issue dut (
        .clk           (clk),
        .resetn        (resetn),
        .ex_valid_i    (ex_valid_i),
        .ex_op_i       (ex_op_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .flush_i       (flush_i),
        .mul_ready_i   (mul_ready_i),
        .mul_result_i  (mul_result_i),
        .mul_start_o   (mul_start_o),
        .mul_annul_o   (mul_annul_o),
        .mul_signed_o  (mul_signed_o),
        .mul_opdata1_o (mul_opdata1_o),
        .mul_opdata2_o (mul_opdata2_o),
        .stall_o       (stall_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .done_o        (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one unit after a rising edge with the DUT in IDLE; returns likewise.
    task automatic run_mul(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] p, input int unsigned lat,
                           input logic exp_sgn, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        ex_valid_i = 1'b1;
        ex_op_i    = op;
        rs_i       = a;
        rt_i       = b;
        #1 check({tag, "_stall_issue"}, stall_o, 1'b1);
        tick();
        check({tag, "_start"}, mul_start_o, 1'b1);
        check({tag, "_signed"}, mul_signed_o, exp_sgn);
        check({tag, "_opd"}, {mul_opdata1_o, mul_opdata2_o}, {a, b});
        // Live EX op changes while busy must not affect the write-back.
        ex_op_i = 3'b001;
        rs_i    = ~a;
        for (int unsigned i = 1; i < lat; i++) tick();
        check({tag, "_stall_busy"}, stall_o, 1'b1);
        ex_valid_i   = 1'b0;
        mul_ready_i  = 1'b1;
        mul_result_i = p;
        #1 check({tag, "_stall_ready"}, stall_o, 1'b0);
        tick();
        mul_ready_i = 1'b0;
        check({tag, "_done"}, done_o, 1'b1);
        check({tag, "_start_drain"}, mul_start_o, 1'b0);
        check({tag, "_hilo"}, {hi_o, lo_o}, {exp_hi, exp_lo});
        tick();
        check({tag, "_done_low"}, done_o, 1'b0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        resetn       = 1'b0;
        ex_valid_i   = 1'b0;
        ex_op_i      = 3'b000;
        rs_i         = '0;
        rt_i         = '0;
        flush_i      = 1'b0;
        mul_ready_i  = 1'b0;
        mul_result_i = '0;
        tick();
        tick();
        check("rst_stall", stall_o, 1'b0);
        check("rst_ctl", {mul_start_o, mul_annul_o, mul_signed_o, done_o}, 4'b0000);
        check("rst_hilo", {hi_o, lo_o}, 64'h0);
        resetn = 1'b1;
        tick();

        run_mul("mult",  3'b001, 32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 4, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_mul("multu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 3, 1'b0, 32'hFFFFFFFE, 32'h00000001);
        run_mul("setup", 3'b010, 32'h00000001, 32'hFFFFFFFF, 64'h00000000_FFFFFFFF, 2, 1'b0, 32'h00000000, 32'hFFFFFFFF);
        run_mul("maddu", 3'b100, 32'h00000001, 32'h00000001, 64'h1, 2, 1'b0, 32'h00000001, 32'h00000000);
        run_mul("zero",  3'b001, 32'h0, 32'h0, 64'h0, 1, 1'b1, 32'h0, 32'h0);
        run_mul("msub",  3'b101, 32'h2, 32'h3, 64'h6, 2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);

        // Flush while a mul op sits in EX in IDLE: no issue.
        ex_valid_i = 1'b1;
        ex_op_i    = 3'b001;
        rs_i       = 32'h9;
        rt_i       = 32'h9;
        flush_i    = 1'b1;
        #1 check("idle_flush_stall", stall_o, 1'b0);
        tick();
        flush_i    = 1'b0;
        ex_valid_i = 1'b0;
        check("idle_flush_nostart", mul_start_o, 1'b0);
        tick();

        // Abort: flush ten cycles after issue.
        ex_valid_i = 1'b1;
        ex_op_i    = 3'b001;
        rs_i       = 32'h5;
        rt_i       = 32'h5;
        tick();
        ex_valid_i = 1'b0;
        for (int unsigned i = 0; i < 9; i++) tick();
        flush_i = 1'b1;
        #1 check("abort_stall", stall_o, 1'b1);
        tick();
        flush_i = 1'b0;
        check("abort_annul", mul_annul_o, 1'b1);
        check("abort_start", mul_start_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        tick();
        check("abort_annul_low", mul_annul_o, 1'b0);
        check("abort_done_low", done_o, 1'b0);
        check("abort_hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
        run_mul("post_abort", 3'b010, 32'h7, 32'h6, 64'h2A, 2, 1'b0, 32'h0, 32'h0000002A);

        // Flush and ready in the same cycle: flush wins.
        ex_valid_i = 1'b1;
        ex_op_i    = 3'b100;
        rs_i       = 32'h1;
        rt_i       = 32'h1;
        tick();
        ex_valid_i   = 1'b0;
        flush_i      = 1'b1;
        mul_ready_i  = 1'b1;
        mul_result_i = 64'h1;
        tick();
        flush_i     = 1'b0;
        mul_ready_i = 1'b0;
        check("fr_annul", mul_annul_o, 1'b1);
        check("fr_done", done_o, 1'b0);
        check("fr_hilo", {hi_o, lo_o}, 64'h2A);
        tick();

        // Back-to-back: the second op waits through DRAIN, then issues from IDLE.
        ex_valid_i = 1'b1;
        ex_op_i    = 3'b010;
        rs_i       = 32'h2;
        rt_i       = 32'h3;
        tick();
        check("b2b_start1", mul_start_o, 1'b1);
        rs_i = 32'h4;
        rt_i = 32'h5;
        tick();
        tick();
        mul_ready_i  = 1'b1;
        mul_result_i = 64'h6;
        #1 check("b2b_stall_ready", stall_o, 1'b0);
        tick();
        mul_ready_i = 1'b0;
        check("b2b_done1", done_o, 1'b1);
        check("b2b_lo1", lo_o, 32'h6);
        check("b2b_drain_start", mul_start_o, 1'b0);
        check("b2b_drain_stall", stall_o, 1'b1);
        tick();
        check("b2b_idle_start", mul_start_o, 1'b0);
        check("b2b_idle_stall", stall_o, 1'b1);
        tick();
        ex_valid_i = 1'b0;
        check("b2b_start2", mul_start_o, 1'b1);
        check("b2b_opd2", {mul_opdata1_o, mul_opdata2_o}, {32'h4, 32'h5});
        tick();
        mul_ready_i  = 1'b1;
        mul_result_i = 64'h14;
        tick();
        mul_ready_i = 1'b0;
        check("b2b_done2", done_o, 1'b1);
        check("b2b_hilo2", {hi_o, lo_o}, 64'h14);
        tick();

        // Reset in the middle of BUSY.
        ex_valid_i = 1'b1;
        ex_op_i    = 3'b001;
        rs_i       = 32'h7;
        rt_i       = 32'h7;
        tick();
        ex_valid_i = 1'b0;
        tick();
        resetn = 1'b0;
        #1 check("mrst_stall", stall_o, 1'b0);
        tick();
        check("mrst_ctl", {mul_start_o, mul_annul_o, mul_signed_o, done_o}, 4'b0000);
        check("mrst_opd", {mul_opdata1_o, mul_opdata2_o}, 64'h0);
        check("mrst_hilo", {hi_o, lo_o}, 64'h0);
        resetn = 1'b1;
        tick();
        run_mul("post_rst", 3'b001, 32'h3, 32'h3, 64'h9, 2, 1'b1, 32'h0, 32'h9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
